// File: rtl/mrfm_sample_packer_pkg.sv
// Shared constants for the MRFM sample packer: control register address,
// control bit positions and sample width.
package mrfm_sample_packer_pkg;

   localparam logic [6:0] FR_MRFM_PACK_CTRL = 7'd32;

   localparam int PACK_CH0_EN  = 0;
   localparam int PACK_CH1_EN  = 1;
   localparam int PACK_CLR_OVR = 2;

   localparam int SAMPLE_W = 16;

   function automatic logic [1:0] words_per_set(input logic ch0_en, input logic ch1_en);
      return {1'b0, ch0_en} + {1'b0, ch1_en};
   endfunction

endpackage

// File: rtl/mrfm_pack_fifo.sv
// mrfm_pack_fifo: sync FIFO with a 0..2 word write port and a 1-word pop.
// Latency: a word written in cycle t is on rd_dat at t+1 when the FIFO was empty.
// Backpressure: rd_vld/rd_rdy; the writer must check level before pushing.
module mrfm_pack_fifo #(
   parameter int DEPTH_LOG2 = 5,
   parameter int W          = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [1:0]          wr_cnt,
   input  logic [W-1:0]        wr0_dat,
   input  logic [W-1:0]        wr1_dat,
   output logic [W-1:0]        rd_dat,
   output logic                rd_vld,
   input  logic                rd_rdy,
   output logic [DEPTH_LOG2:0] level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [W-1:0]          mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wp;
   logic [DEPTH_LOG2-1:0] rp;
   logic                  pop;

   // Level carries the extra bit, so full (2**DEPTH_LOG2) and empty never alias.
   assign rd_vld = (level != '0);
   assign pop    = rd_vld && rd_rdy;
   assign rd_dat = rd_vld ? mem[rp] : '0;

   always_ff @(posedge clock) begin
      if (wr_cnt != 2'd0) mem[wp] <= wr0_dat;
      if (wr_cnt == 2'd2) mem[wp + DEPTH_LOG2'(1)] <= wr1_dat;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         wp    <= wp + DEPTH_LOG2'(wr_cnt);
         rp    <= rp + DEPTH_LOG2'(pop);
         level <= level + (DEPTH_LOG2+1)'(wr_cnt) - (DEPTH_LOG2+1)'(pop);
      end
   end

endmodule

// File: rtl/mrfm_sample_packer.sv
// mrfm_sample_packer: packs enabled i/ip channels per strobe into a 16-bit word FIFO; MRFM_PACKER_STATS_EN adds stats.
// Latency: first word of a set is on data_out one cycle after the strobe when the FIFO was empty.
// Backpressure: data_valid/data_ready; a set that does not fit whole is dropped and sets overrun.
module mrfm_sample_packer
   import mrfm_sample_packer_pkg::*;
#(
   parameter int         DEPTH_LOG2 = 5,
   parameter logic [6:0] CTRL_ADDR  = FR_MRFM_PACK_CTRL
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [6:0]          serial_addr,
   input  logic [31:0]         serial_data,
   input  logic                serial_strobe,
   input  logic                strobe_in,
   input  logic [SAMPLE_W-1:0] i,
   input  logic [SAMPLE_W-1:0] ip,
   output logic [SAMPLE_W-1:0] data_out,
   output logic                data_valid,
   input  logic                data_ready,
   output logic                overrun,
   output logic [DEPTH_LOG2:0] level
`ifdef MRFM_PACKER_STATS_EN
   ,
   output logic [63:0]         stats
`endif
);

   localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic                ch0_en;
   logic                ch1_en;
   logic                ctrl_wr;
   logic                clr_ovr;
   logic [1:0]          n_words;
   logic [DEPTH_LOG2:0] free_words;
   logic                set_fits;
   logic                push;
   logic                drop;
   logic [1:0]          wr_cnt;
   logic [SAMPLE_W-1:0] wr0_dat;
   logic                unused_serial_bits;

   assign ctrl_wr            = serial_strobe && (serial_addr == CTRL_ADDR);
   assign clr_ovr            = ctrl_wr && serial_data[PACK_CLR_OVR];
   assign unused_serial_bits = ^serial_data[31:3];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ch0_en <= 1'b0;
         ch1_en <= 1'b0;
      end else if (ctrl_wr) begin
         ch0_en <= serial_data[PACK_CH0_EN];
         ch1_en <= serial_data[PACK_CH1_EN];
      end
   end

   // Free space uses the pre-pop level, so a same-cycle pop never makes room.
   assign n_words    = words_per_set(ch0_en, ch1_en);
   assign free_words = CAPACITY - level;
   assign set_fits   = free_words >= {{(DEPTH_LOG2-1){1'b0}}, n_words};
   assign push       = strobe_in && (n_words != 2'd0) && set_fits;
   assign drop       = strobe_in && (n_words != 2'd0) && !set_fits;
   assign wr_cnt     = push ? n_words : 2'd0;
   assign wr0_dat    = ch0_en ? i : ip;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)     overrun <= 1'b0;
      else if (drop)    overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
   end

   mrfm_pack_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .W          (SAMPLE_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_cnt  (wr_cnt),
      .wr0_dat (wr0_dat),
      .wr1_dat (ip),
      .rd_dat  (data_out),
      .rd_vld  (data_valid),
      .rd_rdy  (data_ready),
      .level   (level)
   );

`ifdef MRFM_PACKER_STATS_EN
   logic [31:0] sets_written;
   logic [31:0] sets_dropped;

   // A clear restarts the count; an event in the clear cycle still counts as one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sets_written <= '0;
         sets_dropped <= '0;
      end else if (clr_ovr) begin
         sets_written <= {31'd0, push};
         sets_dropped <= {31'd0, drop};
      end else begin
         if (push && !(&sets_written)) sets_written <= sets_written + 32'd1;
         if (drop && !(&sets_dropped)) sets_dropped <= sets_dropped + 32'd1;
      end
   end

   assign stats = {sets_dropped, sets_written};
`endif

endmodule

// File: tb/tb_mrfm_sample_packer.sv
// Self-checking bench for mrfm_sample_packer with an 8-word FIFO.
module tb_mrfm_sample_packer;
   import mrfm_sample_packer_pkg::*;

   localparam int DL2 = 3;

   logic           clock = 1'b0;
   logic           reset_n;
   logic [6:0]     serial_addr;
   logic [31:0]    serial_data;
   logic           serial_strobe;
   logic           strobe_in;
   logic [15:0]    i;
   logic [15:0]    ip;
   logic [15:0]    data_out;
   logic           data_valid;
   logic           data_ready;
   logic           overrun;
   logic [DL2:0]   level;
`ifdef MRFM_PACKER_STATS_EN
   logic [63:0]    stats;
`endif

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];

   mrfm_sample_packer #(.DEPTH_LOG2(DL2)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .serial_addr   (serial_addr),
      .serial_data   (serial_data),
      .serial_strobe (serial_strobe),
      .strobe_in     (strobe_in),
      .i             (i),
      .ip            (ip),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .overrun       (overrun),
      .level         (level)
`ifdef MRFM_PACKER_STATS_EN
      ,
      .stats         (stats)
`endif
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (reset_n && data_valid && data_ready) got_q.push_back(data_out);

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic write_ctrl(input logic [31:0] val);
      serial_addr   = FR_MRFM_PACK_CTRL;
      serial_data   = val;
      serial_strobe = 1'b1;
      step();
      serial_strobe = 1'b0;
      serial_data   = '0;
   endtask

   task automatic send_set(input logic [15:0] a, input logic [15:0] b);
      i         = a;
      ip        = b;
      strobe_in = 1'b1;
      step();
      strobe_in = 1'b0;
   endtask

   task automatic wait_words(input int n, input int budget, output bit timed_out);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         step();
         c++;
      end
      timed_out = (got_q.size() < n);
   endtask

   task automatic test_reset_state;
      checks++;
      if (data_valid !== 1'b0 || level !== '0 || overrun !== 1'b0 || data_out !== 16'h0) begin
         failures++;
         $display("FAIL reset_state valid=%b level=%0d ovr=%b out=%h want 0/0/0/0000",
                  data_valid, level, overrun, data_out);
      end
   endtask

   task automatic test_two_channel;
      bit to;
      got_q.delete();
      write_ctrl(32'h3);
      data_ready = 1'b1;
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'hABCD);
      send_set(16'h1234, 16'hABCD);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
         failures++;
         $display("FAIL two_ch_first valid=%b out=%h want 1/1234", data_valid, data_out);
      end
      step();
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'hABCD) begin
         failures++;
         $display("FAIL two_ch_second valid=%b out=%h want 1/abcd", data_valid, data_out);
      end
      wait_words(exp_q.size(), 20, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL two_ch_timeout got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [15:0] e, g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL two_ch_word got=%h want=%h", g, e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_ch1_only;
      bit to;
      got_q.delete();
      write_ctrl(32'h2);
      data_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back(16'(k));
         send_set(16'hDEAD, 16'(k));
      end
      wait_words(4, 20, to);
      repeat (5) step();
      checks++;
      if (to || got_q.size() != 4) begin
         failures++;
         $display("FAIL ch1_count got=%0d want=4", got_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [15:0] e, g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL ch1_word got=%h want=%h", g, e);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_fill_overrun;
      bit to;
      got_q.delete();
      write_ctrl(32'h3);
      data_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(16'h0100 + 16'(k));
         exp_q.push_back(16'h0200 + 16'(k));
         send_set(16'h0100 + 16'(k), 16'h0200 + 16'(k));
      end
      checks++;
      if (level !== 4'd8 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL full_level level=%0d ovr=%b want 8/0", level, overrun);
      end
      send_set(16'h01FF, 16'h02FF);
      repeat (3) step();
      checks++;
      if (level !== 4'd8 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL full_drop level=%0d ovr=%b want 8/1", level, overrun);
      end
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'h0100) begin
         failures++;
         $display("FAIL held_head valid=%b out=%h want 1/0100", data_valid, data_out);
      end
      data_ready = 1'b1;
      wait_words(8, 40, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL full_drain_timeout got=%0d want=8", got_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [15:0] e, g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL full_word got=%h want=%h", g, e);
         end
      end
      exp_q.delete();
      step();
      checks++;
      if (level !== '0 || data_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_empty level=%0d valid=%b want 0/0", level, data_valid);
      end
   endtask

   task automatic test_prepop_check;
      bit to;
      got_q.delete();
      data_ready = 1'b0;
      write_ctrl(32'h7);
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL prepop_clear ovr=%b want 0", overrun);
      end
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(16'h0500 + 16'(k));
         exp_q.push_back(16'h0600 + 16'(k));
         send_set(16'h0500 + 16'(k), 16'h0600 + 16'(k));
      end
      write_ctrl(32'h1);
      exp_q.push_back(16'h05FF);
      send_set(16'h05FF, 16'h06FF);
      checks++;
      if (level !== 4'd7) begin
         failures++;
         $display("FAIL prepop_level7 level=%0d want 7", level);
      end
      write_ctrl(32'h3);
      data_ready = 1'b1;
      send_set(16'hBAD0, 16'hBAD1);
      data_ready = 1'b0;
      checks++;
      if (level !== 4'd6 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL prepop_drop level=%0d ovr=%b want 6/1", level, overrun);
      end
      data_ready = 1'b1;
      wait_words(7, 40, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL prepop_timeout got=%0d want=7", got_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [15:0] e, g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL prepop_word got=%h want=%h", g, e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_clr_race;
      bit to;
      got_q.delete();
      data_ready = 1'b0;
      write_ctrl(32'h7);
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL race_preclear ovr=%b want 0", overrun);
      end
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(16'h0700 + 16'(k));
         exp_q.push_back(16'h0800 + 16'(k));
         send_set(16'h0700 + 16'(k), 16'h0800 + 16'(k));
      end
      serial_addr   = FR_MRFM_PACK_CTRL;
      serial_data   = 32'h7;
      serial_strobe = 1'b1;
      send_set(16'hEEEE, 16'hFFFF);
      serial_strobe = 1'b0;
      checks++;
      if (overrun !== 1'b1 || level !== 4'd8) begin
         failures++;
         $display("FAIL race_drop_wins ovr=%b level=%0d want 1/8", overrun, level);
      end
      write_ctrl(32'h7);
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL race_second_clear ovr=%b want 0", overrun);
      end
      data_ready = 1'b1;
      wait_words(8, 40, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL race_timeout got=%0d want=8", got_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [15:0] e, g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL race_word got=%h want=%h", g, e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid;
      data_ready = 1'b0;
      write_ctrl(32'h3);
      for (int k = 0; k < 5; k++) send_set(16'h0900 + 16'(k), 16'h0A00 + 16'(k));
      checks++;
      if (level !== 4'd8 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL mid_prefill level=%0d ovr=%b want 8/1", level, overrun);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (data_valid !== 1'b0 || level !== '0 || overrun !== 1'b0 || data_out !== 16'h0) begin
         failures++;
         $display("FAIL mid_reset valid=%b level=%0d ovr=%b out=%h want 0/0/0/0000",
                  data_valid, level, overrun, data_out);
      end
      #2;
      reset_n = 1'b1;
      step();
      got_q.delete();
      data_ready = 1'b1;
      send_set(16'h1111, 16'h2222);
      repeat (2) step();
      checks++;
      if (level !== '0 || data_valid !== 1'b0 || got_q.size() != 0) begin
         failures++;
         $display("FAIL mid_ctrl_cleared level=%0d valid=%b words=%0d want 0/0/0",
                  level, data_valid, got_q.size());
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      serial_addr   = '0;
      serial_data   = '0;
      serial_strobe = 1'b0;
      strobe_in     = 1'b0;
      i             = '0;
      ip            = '0;
      data_ready    = 1'b0;
      #12;
      test_reset_state();
      #10;
      reset_n = 1'b1;
      step();
      test_reset_state();
      test_two_channel();
      test_ch1_only();
      test_fill_overrun();
      test_prepop_check();
      test_clr_race();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
